rca_aprox_pipe: RTL and testbench
=================================

Name: rca_aprox_pipe

Overview:
Parametrised, pipelined successor of the 9-bit approximate ripple-carry adder.
- Operand width and the number of approximated LSBs are generics.
- A per-transaction mode bit selects the approximate or the exact result.
- Operands travel over a valid/ready stream with full backpressure.
- On-chip error statistics (error count, accumulated absolute error, sample count) are built in, so accuracy is characterised in hardware.
- Sits between operand source and consumer in the adder evaluation datapath; results feed the same compare/report logic as earlier adders.

Parameters:
WIDTH, 9, operand width in bits (>=2).
APPROX_BITS, 4, number of low bits computed approximately (0..WIDTH-1); 0 means fully exact.
ACC_WIDTH, 32, width of each statistics counter.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand pair valid.
in_ready  out  1  block can accept an operand pair.
in_a  in  WIDTH  operand A.
in_b  in  WIDTH  operand B.
in_mode  in  1  0 = approximate, 1 = exact; sampled with operands.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
out_sum  out  WIDTH+1  selected sum, carry-out in MSB.
out_exact  out  WIDTH+1  exact A+B for the same transaction.
out_err  out  WIDTH+1  |out_exact - approximate sum|, reported even when in_mode=1.
stats_clr  in  1  synchronous clear of statistics.
err_count  out  ACC_WIDTH  results with out_err != 0.
err_sum  out  ACC_WIDTH  accumulated out_err.
sample_count  out  ACC_WIDTH  results delivered.

Behaviour:
- Approximate sum, with K = APPROX_BITS:
  - Bits i < K: S[i] = A[i] | B[i].
  - Carry into bit K: A[K-1] & B[K-1], or 0 when K=0.
  - Bits K..WIDTH-1: exact ripple with that carry.
  - S[WIDTH] = final carry-out.
- Exact sum: A+B, WIDTH+1 bits, no truncation.
- Pipeline: 2 stages.
  - S1 registers operands and mode.
  - S2 registers approximate sum, exact sum and |difference|, and muxes out_sum by the registered mode.
  - Latency: 2 cycles from input handshake to out_valid with no stall.
- Handshake:
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - S2 holds while out_valid & !out_ready; S1 advances when S2 is empty or transferring.
  - in_ready = !v1 | !v2 | out_ready (combinational; no dependency on in_valid).
  - Full throughput of 1 transfer/cycle with out_ready held high.
- Stability: out_sum, out_exact, out_err and out_valid stay stable while stalled. Transactions are never dropped or duplicated, and order is preserved.
- Statistics update on each output transfer:
  - sample_count += 1.
  - err_count += 1 if out_err != 0.
  - err_sum += out_err.
- Saturation: all three counters saturate at all-ones with no wrap. The err_sum addend is zero-extended.
- stats_clr: zeroes all three counters next cycle. If it coincides with an output transfer, clear wins and that transfer is not counted. It does not affect the pipeline.
- Reset (asserted asynchronously):
  - Pipeline valids cleared, so out_valid=0; in_ready=1 after reset.
  - out_sum, out_exact, out_err = 0; all counters = 0.
  - Reset mid-transaction discards in-flight data.

Test Plan:
- WIDTH=9, K=4, mode=0, A=0x00F, B=0x001 -> out_sum=15, out_exact=16, out_err=1; err_count=1, sample_count=1.
- A=0x008, B=0x008, mode=0 -> out_sum=24, out_exact=16, out_err=8; then A=B=0x1FF -> out_sum=1023, out_exact=1022, out_err=1; err_sum=9.
- Same A=0x008, B=0x008 with mode=1 -> out_sum=16, out_err=8 still reported; K=0 build gives out_err=0 for 1000 random pairs.
- Stream 8 back-to-back pairs, hold out_ready=0 for cycles 3-6 -> in_ready drops once S1/S2 are full, outputs stable while stalled, all 8 results in order, sample_count=8.
- stats_clr asserted in the same cycle as an output transfer -> counters read 0 next cycle; ACC_WIDTH=4 build with 20 erroring samples -> err_count=15, sample_count=15 (saturated).
- Assert rst_n=0 mid-stream with 2 transactions in flight -> out_valid=0 and counters 0 immediately; after release, first new pair appears exactly 2 cycles after acceptance.

Source files
------------

// File: rtl/rca_aprox_pipe.sv
// rca_aprox_pipe: two-stage approximate/exact ripple-carry adder on a valid/ready stream.
// It also counts errors in hardware so that accuracy can be characterised on chip.
module rca_aprox_pipe #(
  parameter int WIDTH       = 9,
  parameter int APPROX_BITS = 4,
  parameter int ACC_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH:0]       out_sum,
  output logic [WIDTH:0]       out_exact,
  output logic [WIDTH:0]       out_err,
  input  logic                 stats_clr,
  output logic [ACC_WIDTH-1:0] err_count,
  output logic [ACC_WIDTH-1:0] err_sum,
  output logic [ACC_WIDTH-1:0] sample_count
);
  localparam int K  = APPROX_BITS;
  localparam int SW = (ACC_WIDTH > WIDTH + 1 ? ACC_WIDTH : WIDTH + 1) + 1;
  logic             v1, v2, m1, adv, xfer;
  logic [WIDTH-1:0] a1, b1;
  logic [WIDTH:0]   apx, exa, dif;
  logic [SW-1:0]    es;
  assign adv       = !v2 | out_ready;
  assign in_ready  = !v1 | adv;
  assign out_valid = v2;
  assign xfer      = v2 & out_ready;
  assign exa       = {1'b0, a1} + {1'b0, b1};
  generate
    if (K == 0) begin : g_exact
      assign apx = exa;
    end else begin : g_apx
      // Low bits are OR-ed; the carry into bit K is guessed from bit K-1 alone.
      logic [WIDTH-K:0] hi;
      assign hi  = {1'b0, a1[WIDTH-1:K]} + {1'b0, b1[WIDTH-1:K]} +
                   {{(WIDTH-K){1'b0}}, a1[K-1] & b1[K-1]};
      assign apx = {hi, a1[K-1:0] | b1[K-1:0]};
    end
  endgenerate
  assign dif = exa >= apx ? exa - apx : apx - exa;
  assign es  = SW'(err_sum) + SW'(out_err);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      a1        <= '0;
      b1        <= '0;
      m1        <= 1'b0;
      out_sum   <= '0;
      out_exact <= '0;
      out_err   <= '0;
    end else begin
      if (in_ready) v1 <= in_valid;
      if (in_valid & in_ready) begin
        a1 <= in_a;
        b1 <= in_b;
        m1 <= in_mode;
      end
      if (adv) v2 <= v1;
      if (adv & v1) begin
        out_sum   <= m1 ? exa : apx;
        out_exact <= exa;
        out_err   <= dif;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count    <= '0;
      err_sum      <= '0;
      sample_count <= '0;
    end else if (stats_clr) begin
      err_count    <= '0;
      err_sum      <= '0;
      sample_count <= '0;
    end else if (xfer) begin
      sample_count <= &sample_count ? sample_count : sample_count + 1'b1;
      err_count    <= (&err_count || out_err == '0) ? err_count : err_count + 1'b1;
      err_sum      <= es > SW'({ACC_WIDTH{1'b1}}) ? '1 : es[ACC_WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_rca_aprox_pipe.sv
// tb_rca_aprox_pipe: randomized and directed checks of rca_aprox_pipe against an arithmetic model.
// Three builds share the stimulus: default, fully exact (K=0) and 4-bit saturating counters.
module tb_rca_aprox_pipe;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_mode = 0, out_ready = 0, stats_clr = 0;
  logic [8:0] in_a = 0, in_b = 0;
  logic in_ready, out_valid, k_rdy, k_vld, s_rdy, s_vld;
  logic [9:0] out_sum, out_exact, out_err, k_sum, k_exact, k_err, s_sum, s_exact, s_err;
  logic [31:0] err_count, err_sum, sample_count, k_ec, k_es, k_sc;
  logic [3:0] s_ec, s_es, s_sc;
  int checks = 0, passes = 0;
  bit in_fire, out_fire, last_rdy;
  logic [39:0] got_q[$], exp_q[$];
  logic [29:0] pq[$];
  int n, ec, es, sn, sec, ses;

  always #5 clk = ~clk;

  rca_aprox_pipe #(.WIDTH(9), .APPROX_BITS(4), .ACC_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_exact(out_exact), .out_err(out_err), .stats_clr(stats_clr), .err_count(err_count),
    .err_sum(err_sum), .sample_count(sample_count));
  rca_aprox_pipe #(.WIDTH(9), .APPROX_BITS(0), .ACC_WIDTH(32)) dut_k0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(k_rdy), .in_a(in_a), .in_b(in_b),
    .in_mode(in_mode), .out_valid(k_vld), .out_ready(out_ready), .out_sum(k_sum),
    .out_exact(k_exact), .out_err(k_err), .stats_clr(stats_clr), .err_count(k_ec),
    .err_sum(k_es), .sample_count(k_sc));
  rca_aprox_pipe #(.WIDTH(9), .APPROX_BITS(4), .ACC_WIDTH(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_rdy), .in_a(in_a), .in_b(in_b),
    .in_mode(in_mode), .out_valid(s_vld), .out_ready(out_ready), .out_sum(s_sum),
    .out_exact(s_exact), .out_err(s_err), .stats_clr(stats_clr), .err_count(s_ec),
    .err_sum(s_es), .sample_count(s_sc));

  // Reference: approximate sum built from the textual rule with integer arithmetic.
  function automatic logic [29:0] model(int a, int b, bit m);
    int low, c, hi, ap, ex, er;
    low = (a | b) % 16;
    c   = (a >> 3) & (b >> 3) & 1;
    hi  = (a >> 4) + (b >> 4) + c;
    ap  = hi * 16 + low;
    ex  = a + b;
    er  = ex > ap ? ex - ap : ap - ex;
    return {10'(m ? ex : ap), 10'(ex), 10'(er)};
  endfunction

  task automatic step(input logic iv, input logic [8:0] a, input logic [8:0] b, input logic m,
                      input logic ordy, input logic clr);
    logic [29:0] e;
    int er;
    in_valid = iv; in_a = a; in_b = b; in_mode = m; out_ready = ordy; stats_clr = clr;
    #1;
    last_rdy = in_ready;
    in_fire  = in_valid & in_ready;
    out_fire = out_valid & out_ready;
    if (in_fire) begin
      e = model(int'(a), int'(b), m);
      exp_q.push_back({10'd0, e});
      pq.push_back(e);
    end
    er = 0;
    if (out_fire) begin
      got_q.push_back({k_err, out_sum, out_exact, out_err});
      if (pq.size() > 0) begin
        e = pq.pop_front();
        er = int'(e[9:0]);
      end
    end
    if (clr) begin
      n = 0; ec = 0; es = 0; sn = 0; sec = 0; ses = 0;
    end else if (out_fire) begin
      n++; es += er;
      if (er != 0) ec++;
      if (er != 0 && sec < 15) sec++;
      if (sn < 15) sn++;
      ses = ses + er > 15 ? 15 : ses + er;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && pq.size() > 0; c++) step(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_reset();
    rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset out_valid got %b want 0", out_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset in_ready got %b want 1", in_ready); else passes++;
    checks++; if ({out_sum, out_exact, out_err} !== 30'd0) $display("FAIL reset outputs got %h want 0", {out_sum, out_exact, out_err}); else passes++;
    checks++; if ({err_count, err_sum, sample_count} !== 96'd0) $display("FAIL reset counters got %h want 0", {err_count, err_sum, sample_count}); else passes++;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    step(0, 0, 0, 0, 1, 1);
    step(1, 9'h00F, 9'h001, 0, 1, 0);
    drain();
    checks++; if (got_q.size() != 1) $display("FAIL dir1 count got %0d want 1", got_q.size()); else passes++;
    checks++; if (got_q[0][29:0] !== {10'd15, 10'd16, 10'd1}) $display("FAIL dir1 result got %h want %h", got_q[0][29:0], {10'd15, 10'd16, 10'd1}); else passes++;
    checks++; if (err_count !== 1 || sample_count !== 1) $display("FAIL dir1 stats got ec=%0d sc=%0d want 1 1", err_count, sample_count); else passes++;
    got_q.delete(); exp_q.delete();
    step(0, 0, 0, 0, 1, 1);
    step(1, 9'h008, 9'h008, 0, 1, 0);
    step(1, 9'h1FF, 9'h1FF, 0, 1, 0);
    step(1, 9'h008, 9'h008, 1, 1, 0);
    drain();
    checks++; if (got_q[0][29:0] !== {10'd24, 10'd16, 10'd8}) $display("FAIL dir2 result got %h want %h", got_q[0][29:0], {10'd24, 10'd16, 10'd8}); else passes++;
    checks++; if (got_q[1][29:0] !== {10'd1023, 10'd1022, 10'd1}) $display("FAIL dir3 result got %h want %h", got_q[1][29:0], {10'd1023, 10'd1022, 10'd1}); else passes++;
    checks++; if (got_q[2][29:0] !== {10'd16, 10'd16, 10'd8}) $display("FAIL dir_exact result got %h want %h", got_q[2][29:0], {10'd16, 10'd16, 10'd8}); else passes++;
    checks++; if (err_sum !== 17 || err_count !== 3) $display("FAIL dir stats got es=%0d ec=%0d want 17 3", err_sum, err_count); else passes++;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random(input int total);
    int sent = 0;
    step(0, 0, 0, 0, 1, 1);
    for (int c = 0; c < 8000 && (sent < total || pq.size() > 0); c++) begin
      step(sent < total && $urandom_range(0, 3) != 0, 9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)),
           1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, 0);
      if (in_fire) sent++;
    end
    checks++; if (got_q.size() != total) $display("FAIL rand count got %0d want %0d", got_q.size(), total); else passes++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL rand[%0d] got %h want %h", i, i < got_q.size() ? got_q[i] : 40'h0, exp_q[i]);
      else passes++;
    end
    checks++; if (sample_count !== 32'(n) || err_count !== 32'(ec) || err_sum !== 32'(es)) $display("FAIL rand stats got %0d %0d %0d want %0d %0d %0d", sample_count, err_count, err_sum, n, ec, es); else passes++;
    checks++; if (s_sc !== 4'(sn) || s_ec !== 4'(sec) || s_es !== 4'(ses)) $display("FAIL rand sat stats got %0d %0d %0d want %0d %0d %0d", s_sc, s_ec, s_es, sn, sec, ses); else passes++;
    checks++; if (k_ec !== 0 || k_es !== 0 || k_sc !== 32'(n)) $display("FAIL k0 stats got ec=%0d es=%0d sc=%0d want 0 0 %0d", k_ec, k_es, k_sc, n); else passes++;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [8:0] pa[8], pb[8];
    logic [30:0] saved;
    bit stall, blocked = 0;
    int idx = 0;
    for (int i = 0; i < 8; i++) begin pa[i] = 9'($urandom_range(0, 511)); pb[i] = 9'($urandom_range(0, 511)); end
    step(0, 0, 0, 0, 1, 1);
    for (int c = 0; c < 40 && got_q.size() < 8; c++) begin
      logic ordy;
      ordy  = !(c >= 3 && c <= 6);
      stall = out_valid && !ordy;
      saved = {out_valid, out_sum, out_exact, out_err};
      step(idx < 8, idx < 8 ? pa[idx] : 9'd0, idx < 8 ? pb[idx] : 9'd0, 0, ordy, 0);
      if (in_fire) idx++;
      if (idx < 8 && !last_rdy) blocked = 1;
      if (stall) begin
        checks++;
        if ({out_valid, out_sum, out_exact, out_err} !== saved)
          $display("FAIL b2b stall c=%0d got %h want %h", c, {out_valid, out_sum, out_exact, out_err}, saved);
        else passes++;
      end
    end
    checks++; if (!blocked) $display("FAIL b2b in_ready got always 1 want a drop"); else passes++;
    checks++; if (got_q.size() != 8) $display("FAIL b2b count got %0d want 8", got_q.size()); else passes++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL b2b[%0d] got %h want %h", i, i < got_q.size() ? got_q[i] : 40'h0, exp_q[i]);
      else passes++;
    end
    checks++; if (sample_count !== 8) $display("FAIL b2b sample_count got %0d want 8", sample_count); else passes++;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_stats_clr();
    step(0, 0, 0, 0, 1, 1);
    step(1, 9'h008, 9'h008, 0, 0, 0);
    for (int c = 0; c < 10 && !out_valid; c++) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    checks++; if (got_q.size() != 1 || out_valid !== 1'b0) $display("FAIL clr xfer got n=%0d vld=%b want 1 0", got_q.size(), out_valid); else passes++;
    checks++; if ({err_count, err_sum, sample_count} !== 96'd0) $display("FAIL clr counters got %0d %0d %0d want 0 0 0", err_count, err_sum, sample_count); else passes++;
    step(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 20; i++) step(1, 9'h008, 9'h008, 0, 1, 0);
    drain();
    checks++; if (s_ec !== 15 || s_sc !== 15 || s_es !== 15) $display("FAIL sat counters got ec=%0d sc=%0d es=%0d want 15 15 15", s_ec, s_sc, s_es); else passes++;
    checks++; if (sample_count !== 20 || err_sum !== 160) $display("FAIL wide counters got sc=%0d es=%0d want 20 160", sample_count, err_sum); else passes++;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midstream();
    logic [29:0] e;
    step(1, 9'h0F0, 9'h10F, 0, 0, 0);
    step(1, 9'h033, 9'h0CC, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL midrst handshake got vld=%b rdy=%b want 0 1", out_valid, in_ready); else passes++;
    checks++; if ({err_count, err_sum, sample_count} !== 96'd0) $display("FAIL midrst counters got %0d %0d %0d want 0 0 0", err_count, err_sum, sample_count); else passes++;
    @(negedge clk);
    rst_n = 1;
    pq.delete(); got_q.delete(); exp_q.delete();
    n = 0; ec = 0; es = 0; sn = 0; sec = 0; ses = 0;
    e = model(9'h0AB, 9'h155, 1'b0);
    step(1, 9'h0AB, 9'h155, 0, 1, 0);
    checks++; if (!in_fire || out_valid !== 1'b0) $display("FAIL midrst cycle1 got fire=%b vld=%b want 1 0", in_fire, out_valid); else passes++;
    step(0, 0, 0, 0, 0, 0);
    checks++; if (out_valid !== 1'b1 || {out_sum, out_exact, out_err} !== e) $display("FAIL midrst cycle2 got vld=%b %h want 1 %h", out_valid, {out_sum, out_exact, out_err}, e); else passes++;
    step(0, 0, 0, 0, 1, 0);
    checks++; if (got_q.size() != 1 || out_valid !== 1'b0) $display("FAIL midrst drain got n=%0d vld=%b want 1 0", got_q.size(), out_valid); else passes++;
  endtask

  initial begin
    n = 0; ec = 0; es = 0; sn = 0; sec = 0; ses = 0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random(1000);
    test_back_to_back();
    test_stats_clr();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
